// File: rtl/sa_input_skewer_pkg.sv
// Shared types and constants for the systolic-array input skewer.
// The skew triangle is stored flat, so tri_base gives the first register of each row.
package sa_input_skewer_pkg;

   localparam int SA_DIM          = 4;
   localparam int SA_BIT_W        = 32;
   localparam int SKEW_FIFO_DEPTH = 4;

   typedef logic [SA_DIM-1:0][SA_BIT_W-1:0] row_vec_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } skew_state_e;

   function automatic int tri_base(input int row);
      return row * (row + 1) / 2;
   endfunction

endpackage

// File: rtl/sa_vec_fifo.sv
// Synchronous FIFO holding whole activation vectors together with their last-of-pass tag.
// The read side is combinational from the head entry, so a pop consumes the data shown this cycle.
module sa_vec_fifo
   import sa_input_skewer_pkg::*;
#(
   parameter int DIM   = SA_DIM,
   parameter int BIT_W = SA_BIT_W,
   parameter int DEPTH = SKEW_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        push,
   input  logic [DIM-1:0][BIT_W-1:0]   wr_vec,
   input  logic                        wr_last,
   input  logic                        pop,
   output logic [DIM-1:0][BIT_W-1:0]   rd_vec,
   output logic                        rd_last,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DIM-1:0][BIT_W-1:0] vec_mem [DEPTH];
   logic                      last_mem [DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;
   logic                      push_ok;
   logic                      pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rd_vec  = vec_mem[rd_ptr];
   assign rd_last = last_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         vec_mem[wr_ptr]  <= wr_vec;
         last_mem[wr_ptr] <= wr_last;
      end
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sa_input_skewer.sv
// Buffers activation vectors and emits them diagonally skewed onto the systolic array's left edge.
// Row i sees an element i cycles after row 0; a tagged last vector is drained and then done pulses.
module sa_input_skewer
   import sa_input_skewer_pkg::*;
#(
   parameter int DIM        = SA_DIM,
   parameter int BIT_W      = SA_BIT_W,
   parameter int FIFO_DEPTH = SKEW_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DIM*BIT_W-1:0]   in_vec,
   input  logic                   in_last,
   input  logic                   en,
   output logic [DIM*BIT_W-1:0]   left_out,
   output logic [DIM-1:0]         left_valid,
   output logic                   busy,
   output logic                   done
);

   localparam int CNT_W = $clog2(DIM) + 1;
   localparam int NREG  = DIM * (DIM + 1) / 2;
   localparam int AW    = $clog2(FIFO_DEPTH);

   logic [DIM-1:0][BIT_W-1:0] rd_vec;
   logic                      rd_last;
   logic                      full;
   logic                      empty;
   logic [AW:0]               count;
   logic                      push;
   logic                      pop;

   skew_state_e               state;
   skew_state_e               state_n;
   logic [CNT_W-1:0]          cnt;
   logic [CNT_W-1:0]          cnt_n;

   logic [BIT_W-1:0]          skew_data [NREG];
   logic                      skew_vld  [NREG];

   // Gating with rstn keeps the producer stalled for the whole reset window.
   assign in_ready = rstn & ~full;
   assign push     = in_valid & in_ready;
   assign pop      = en & ~empty & ((state == IDLE) || (state == STREAM));
   assign done     = (state == DONE);
   assign busy     = (state != IDLE) || (count != '0);

   sa_vec_fifo #(
      .DIM   (DIM),
      .BIT_W (BIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (push),
      .wr_vec  (in_vec),
      .wr_last (in_last),
      .pop     (pop),
      .rd_vec  (rd_vec),
      .rd_last (rd_last),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // Stage 0 of every row takes the popped vector or a zero bubble; deeper stages shift.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NREG; k++) begin
            skew_data[k] <= '0;
            skew_vld[k]  <= 1'b0;
         end
      end else if (en) begin
         for (int r = 0; r < DIM; r++) begin
            skew_data[tri_base(r)] <= pop ? rd_vec[r] : '0;
            skew_vld[tri_base(r)]  <= pop;
            for (int s = 1; s <= r; s++) begin
               skew_data[tri_base(r) + s] <= skew_data[tri_base(r) + s - 1];
               skew_vld[tri_base(r) + s]  <= skew_vld[tri_base(r) + s - 1];
            end
         end
      end
   end

   always_comb begin
      left_out   = '0;
      left_valid = '0;
      for (int r = 0; r < DIM; r++) begin
         left_out[r*BIT_W +: BIT_W] = skew_data[tri_base(r) + r];
         left_valid[r]              = skew_vld[tri_base(r) + r];
      end
   end

   // The drain count is timed so DONE coincides with the last row showing the last element.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE, STREAM: begin
            if (pop) begin
               if (rd_last) begin
                  if (DIM == 1) begin
                     state_n = DONE;
                  end else begin
                     state_n = DRAIN;
                     cnt_n   = CNT_W'(DIM - 1);
                  end
               end else begin
                  state_n = STREAM;
               end
            end
         end
         DRAIN: begin
            if (en) begin
               if (cnt == CNT_W'(1)) state_n = DONE;
               cnt_n = cnt - CNT_W'(1);
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

endmodule

// File: tb/tb_sa_input_skewer.sv
// Directed bench for sa_input_skewer (DIM=4, BIT_W=32, FIFO_DEPTH=4).
// A four-deep history of expected stage-0 loads gives the expected diagonal on left_out.
module tb_sa_input_skewer;

   logic         clk = 1'b0;
   logic         rstn;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_vec;
   logic         in_last;
   logic         en;
   logic [127:0] left_out;
   logic [3:0]   left_valid;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [127:0] h_vec [4];
   logic         h_vld [4];

   always #5 clk = ~clk;

   sa_input_skewer #(
      .DIM        (4),
      .BIT_W      (32),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_vec     (in_vec),
      .in_last    (in_last),
      .en         (en),
      .left_out   (left_out),
      .left_valid (left_valid),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hist();
      for (int i = 0; i < 4; i++) begin
         h_vec[i] = '0;
         h_vld[i] = 1'b0;
      end
   endtask

   function automatic logic [127:0] mkvec(input logic [31:0] base);
      return {base + 32'd3, base + 32'd2, base + 32'd1, base};
   endfunction

   function automatic logic [127:0] exp_out();
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (h_vld[i]) r[32*i +: 32] = h_vec[i][32*i +: 32];
      return r;
   endfunction

   function automatic logic [3:0] exp_vld();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = h_vld[i];
      return v;
   endfunction

   // One clock: pv/pvld is what stage 0 should load at this edge (ignored when en is low).
   task automatic cyc(input string tag, input logic [127:0] pv, input logic pvld,
                      input logic exp_done);
      logic was_en;
      was_en = en;
      tick();
      if (was_en) begin
         for (int i = 3; i > 0; i--) begin
            h_vec[i] = h_vec[i-1];
            h_vld[i] = h_vld[i-1];
         end
         h_vec[0] = pv;
         h_vld[0] = pvld;
      end
      check({tag, ".out"},  left_out, exp_out());
      check({tag, ".vld"},  {124'b0, left_valid}, {124'b0, exp_vld()});
      check({tag, ".done"}, {127'b0, done}, {127'b0, exp_done});
   endtask

   logic [127:0] v_single;
   logic [127:0] va, vb, vc, vw, vx, v1, v2;

   initial begin
      v_single = {32'hc919ca88, 32'h4abf5cf8, 32'h499c2468, 32'h4ac25fb5};
      va = mkvec(32'h1000_0000);
      vb = mkvec(32'h2000_0000);
      vc = mkvec(32'h3000_0000);
      v1 = mkvec(32'h5000_0000);
      v2 = mkvec(32'h6000_0000);
      vw = mkvec(32'h7000_0000);
      vx = mkvec(32'h8000_0000);

      // Reset with a vector offered: nothing may be captured.
      rstn     = 1'b0;
      in_valid = 1'b1;
      in_vec   = {4{32'h4ac25fb5}};
      in_last  = 1'b1;
      en       = 1'b1;
      clear_hist();
      tick();
      tick();
      check("rst.out",   left_out, '0);
      check("rst.vld",   {124'b0, left_valid}, '0);
      check("rst.done",  {127'b0, done}, '0);
      check("rst.ready", {127'b0, in_ready}, '0);
      check("rst.busy",  {127'b0, busy}, '0);
      rstn     = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rel.ready", {127'b0, in_ready}, 128'd1);
      cyc("rel.idle", '0, 1'b0, 1'b0);
      check("rel.busy", {127'b0, busy}, '0);

      // Single last vector: one diagonal, done with row 3.
      in_valid = 1'b1;
      in_vec   = v_single;
      in_last  = 1'b1;
      cyc("one.e0", '0, 1'b0, 1'b0);
      in_valid = 1'b0;
      check("one.busy", {127'b0, busy}, 128'd1);
      cyc("one.e1", v_single, 1'b1, 1'b0);
      cyc("one.e2", '0, 1'b0, 1'b0);
      cyc("one.e3", '0, 1'b0, 1'b0);
      cyc("one.e4", '0, 1'b0, 1'b1);
      check("one.row3", {96'b0, left_out[127:96]}, 128'hc919ca88);
      cyc("one.e5", '0, 1'b0, 1'b0);
      check("one.idle", {127'b0, busy}, '0);

      // Back-to-back vectors, last on the third.
      in_valid = 1'b1; in_vec = va; in_last = 1'b0;
      cyc("b2b.e0", '0, 1'b0, 1'b0);
      in_vec = vb;
      cyc("b2b.e1", va, 1'b1, 1'b0);
      in_vec = vc; in_last = 1'b1;
      cyc("b2b.e2", vb, 1'b1, 1'b0);
      in_valid = 1'b0;
      cyc("b2b.e3", vc, 1'b1, 1'b0);
      cyc("b2b.e4", '0, 1'b0, 1'b0);
      cyc("b2b.e5", '0, 1'b0, 1'b0);
      cyc("b2b.e6", '0, 1'b0, 1'b1);
      cyc("b2b.e7", '0, 1'b0, 1'b0);
      check("b2b.idle", {127'b0, busy}, '0);

      // Backpressure: en low, five offers, only four fit.
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_vec   = mkvec(32'h4000_0000 + 32'(k) * 32'h10);
         in_last  = (k >= 3);
         #1;
         check($sformatf("bp.ready%0d", k), {127'b0, in_ready}, {127'b0, (k < 4)});
         cyc($sformatf("bp.push%0d", k), '0, 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) cyc("bp.hold", '0, 1'b0, 1'b0);
      check("bp.full", {127'b0, in_ready}, '0);
      check("bp.busy", {127'b0, busy}, 128'd1);
      en = 1'b1;
      for (int k = 0; k < 4; k++)
         cyc($sformatf("bp.pop%0d", k), mkvec(32'h4000_0000 + 32'(k) * 32'h10), 1'b1, 1'b0);
      check("bp.ready_again", {127'b0, in_ready}, 128'd1);
      cyc("bp.d0", '0, 1'b0, 1'b0);
      cyc("bp.d1", '0, 1'b0, 1'b0);
      cyc("bp.d2", '0, 1'b0, 1'b1);
      cyc("bp.d3", '0, 1'b0, 1'b0);
      check("bp.idle", {127'b0, busy}, '0);

      // Starvation: two idle edges between vectors leave a bubble on the diagonal.
      in_valid = 1'b1; in_vec = v1; in_last = 1'b0;
      cyc("stv.e0", '0, 1'b0, 1'b0);
      in_valid = 1'b0;
      cyc("stv.e1", v1, 1'b1, 1'b0);
      cyc("stv.e2", '0, 1'b0, 1'b0);
      in_valid = 1'b1; in_vec = v2; in_last = 1'b1;
      cyc("stv.e3", '0, 1'b0, 1'b0);
      in_valid = 1'b0;
      cyc("stv.e4", v2, 1'b1, 1'b0);
      cyc("stv.e5", '0, 1'b0, 1'b0);
      cyc("stv.e6", '0, 1'b0, 1'b0);
      cyc("stv.e7", '0, 1'b0, 1'b1);
      cyc("stv.e8", '0, 1'b0, 1'b0);
      check("stv.idle", {127'b0, busy}, '0);

      // en low for three cycles during drain delays done by three.
      in_valid = 1'b1; in_vec = vw; in_last = 1'b1;
      cyc("frz.e0", '0, 1'b0, 1'b0);
      in_valid = 1'b0;
      cyc("frz.e1", vw, 1'b1, 1'b0);
      cyc("frz.e2", '0, 1'b0, 1'b0);
      en = 1'b0;
      for (int k = 0; k < 3; k++) cyc($sformatf("frz.hold%0d", k), '0, 1'b0, 1'b0);
      en = 1'b1;
      cyc("frz.e6", '0, 1'b0, 1'b0);
      cyc("frz.e7", '0, 1'b0, 1'b1);
      cyc("frz.e8", '0, 1'b0, 1'b0);

      // Reset pulse mid-drain wipes the wavefront and suppresses done.
      in_valid = 1'b1; in_vec = vx; in_last = 1'b1;
      cyc("mrst.e0", '0, 1'b0, 1'b0);
      in_valid = 1'b0;
      cyc("mrst.e1", vx, 1'b1, 1'b0);
      cyc("mrst.e2", '0, 1'b0, 1'b0);
      rstn = 1'b0;
      #1;
      check("mrst.out",  left_out, '0);
      check("mrst.vld",  {124'b0, left_valid}, '0);
      check("mrst.busy", {127'b0, busy}, '0);
      clear_hist();
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 5; k++) cyc($sformatf("mrst.after%0d", k), '0, 1'b0, 1'b0);
      check("mrst.idle", {127'b0, busy}, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
